i2c_reg_bank: RTL

//  Register bank sitting directly downstream of i2c_peripheral_clk.

---
 rtl/i2c_reg_bank_pkg.sv | 20 ++
 rtl/i2c_reg_bank.sv | 119 +++++++++++
 2 files changed

// File: rtl/i2c_reg_bank_pkg.sv
// Shared types and reset contents for the I2C register bank.
// REG_RESET is sized for the largest pointer a single I2C byte can carry.
package i2c_reg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PTR,
        WRITE,
        READ
    } state_t;

    localparam int unsigned MAX_REGS = 256;

    localparam logic [7:0] REG_RESET [MAX_REGS] = '{default: 8'h00};

    function automatic logic [7:0] reg_reset_val(input int unsigned idx);
        return REG_RESET[idx];
    endfunction

endpackage

// File: rtl/i2c_reg_bank.sv
// I2C register bank: pointer-then-data writes, auto-incrementing reads,
// and a host-side port onto the same flop-based register array.
module i2c_reg_bank
    import i2c_reg_pkg::*;
#(
    parameter int unsigned                  ADDR_W  = 4,
    parameter logic [(2**ADDR_W)-1:0]       RO_MASK = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_det,
    input  logic              stop_det,
    input  logic              addr_match,
    input  logic              rw,
    input  logic [7:0]        rx,
    input  logic              rx_valid,
    input  logic              tx_load,
    output logic [7:0]        tx,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    input  logic              host_we,
    output logic [7:0]        host_rdata,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy
);

    localparam int unsigned NUM_REGS = 2**ADDR_W;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;
    logic              i2c_we;
    logic [7:0]        regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Bus framing events override every byte-level event in the same cycle.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        i2c_we     = 1'b0;
        if (start_det || stop_det) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (addr_match) begin
                        state_next = rw ? READ : WAIT_PTR;
                    end
                end
                WAIT_PTR: begin
                    if (rx_valid) begin
                        ptr_next   = rx[ADDR_W-1:0];
                        state_next = WRITE;
                    end
                end
                WRITE: begin
                    if (rx_valid) begin
                        i2c_we   = !RO_MASK[ptr];
                        ptr_next = ptr + ADDR_W'(1);
                    end
                end
                READ: begin
                    if (tx_load) begin
                        ptr_next = ptr + ADDR_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Host write is issued last so it wins a same-index collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= reg_reset_val(i);
            end
        end else begin
            if (i2c_we) begin
                regs[ptr] <= rx;
            end
            if (host_we) begin
                regs[host_addr] <= host_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx         <= '0;
            host_rdata <= '0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
        end else begin
            tx         <= regs[ptr];
            host_rdata <= regs[host_addr];
            wr_strobe  <= i2c_we;
            if (i2c_we) begin
                wr_addr <= ptr;
            end
        end
    end

    always_comb begin
        busy = (state != IDLE);
    end

endmodule
